// File: rtl/spi_buf_pkg.sv
// Shared constants for the SPI byte buffer.
// Holds the default FIFO geometry and the bit positions inside buf_err,
// so that the buffer, the register block and spi_dma decode the error
// vector the same way.
package spi_buf_pkg;

    localparam int SPI_BUF_DEPTH = 8;
    localparam int SPI_BUF_AW    = 3;

    // Bit positions inside buf_err = {rx_udf, rx_ovf, tx_udf, tx_ovf}
    localparam int ERR_TX_OVF = 0;
    localparam int ERR_TX_UDF = 1;
    localparam int ERR_RX_OVF = 2;
    localparam int ERR_RX_UDF = 3;
    localparam int ERR_W      = 4;

endpackage

// File: rtl/spi_buf_fifo.sv
// spi_fifo: show-ahead byte FIFO used for both directions of the SPI buffer.
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   clr            synchronous flush; drops same-cycle push/pop, no errors
//   push, wdata    write request and data
//   pop            read request (consumes the current head)
//   rdata          head entry, combinational from storage (undefined when empty)
//   full, empty    occupancy flags from registered pointers
//   level          occupancy 0..DEPTH
//   ovf, udf       single-cycle pulses for a rejected push / rejected pop
module spi_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          push,
    input  logic [7:0]    wdata,
    input  logic          pop,
    output logic [7:0]    rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          ovf,
    output logic          udf
);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic        push_ok;
    logic        pop_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign level = wr_ptr_reg - rd_ptr_reg;

    // A push into a full FIFO is still fine when a pop frees a slot in the
    // same cycle; an empty FIFO never satisfies a pop, even with a push.
    assign pop_ok  = pop && !empty && !clr;
    assign push_ok = push && (!full || pop_ok) && !clr;
    assign ovf     = push && !push_ok && !clr;
    assign udf     = pop && !pop_ok && !clr;

    assign rdata = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/spi_buf.sv
// spi_buf: byte buffering between spi_dma and the SPI shift engine.
// Two independent show-ahead FIFOs (TX: DMA -> shifter, RX: shifter -> DMA)
// plus a sticky error register {rx_udf, rx_ovf, tx_udf, tx_ovf}.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   buf_clr / err_clr         flush both FIFOs + errors / clear errors only
//   tx_byte_vld, tx_byte      DMA push into TX;   tx_buf_rdy = TX not full
//   rx_byte_req, rx_byte      DMA pop from RX;    rx_buf_rdy = RX not empty
//   sft_tx_req, sft_tx_byte   shifter pop from TX; sft_tx_vld = TX not empty
//   sft_rx_vld, sft_rx_byte   shifter push into RX
//   tx_level, rx_level        occupancy 0..DEPTH
//   buf_err                   sticky error flags
module spi_buf
    import spi_buf_pkg::*;
#(
    parameter int DEPTH = SPI_BUF_DEPTH,
    parameter int AW    = SPI_BUF_AW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          buf_clr,
    input  logic          err_clr,
    input  logic          tx_byte_vld,
    input  logic [7:0]    tx_byte,
    output logic          tx_buf_rdy,
    input  logic          rx_byte_req,
    output logic [7:0]    rx_byte,
    output logic          rx_buf_rdy,
    input  logic          sft_tx_req,
    output logic [7:0]    sft_tx_byte,
    output logic          sft_tx_vld,
    input  logic          sft_rx_vld,
    input  logic [7:0]    sft_rx_byte,
    output logic [AW:0]   tx_level,
    output logic [AW:0]   rx_level,
    output logic [3:0]    buf_err
);

    logic             tx_full;
    logic             tx_empty;
    logic             rx_full;
    logic             rx_empty;
    logic             tx_ovf;
    logic             tx_udf;
    logic             rx_ovf;
    logic             rx_udf;
    logic [ERR_W-1:0] err_new;
    logic [ERR_W-1:0] err_reg;
    logic [ERR_W-1:0] err_next;

    spi_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_tx_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (buf_clr),
        .push  (tx_byte_vld),
        .wdata (tx_byte),
        .pop   (sft_tx_req),
        .rdata (sft_tx_byte),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level),
        .ovf   (tx_ovf),
        .udf   (tx_udf)
    );

    spi_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_rx_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (buf_clr),
        .push  (sft_rx_vld),
        .wdata (sft_rx_byte),
        .pop   (rx_byte_req),
        .rdata (rx_byte),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level),
        .ovf   (rx_ovf),
        .udf   (rx_udf)
    );

    assign tx_buf_rdy = !tx_full;
    assign sft_tx_vld = !tx_empty;
    assign rx_buf_rdy = !rx_empty;

    always_comb begin
        err_new             = '0;
        err_new[ERR_TX_OVF] = tx_ovf;
        err_new[ERR_TX_UDF] = tx_udf;
        err_new[ERR_RX_OVF] = rx_ovf;
        err_new[ERR_RX_UDF] = rx_udf;
    end

    // A new error in the same cycle as err_clr survives the clear.
    always_comb begin
        err_next = (err_clr ? '0 : err_reg) | err_new;
        if (buf_clr) err_next = '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) err_reg <= '0;
        else       err_reg <= err_next;
    end

    assign buf_err = err_reg;

endmodule

// File: tb/tb_spi_buf.sv
// Self-checking bench for spi_buf: a queue-based reference model checked
// against the DUT every cycle, plus directed scenarios with literal values.
module tb_spi_buf;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          buf_clr = 1'b0;
    logic          err_clr = 1'b0;
    logic          tx_byte_vld = 1'b0;
    logic [7:0]    tx_byte = 8'h00;
    logic          tx_buf_rdy;
    logic          rx_byte_req = 1'b0;
    logic [7:0]    rx_byte;
    logic          rx_buf_rdy;
    logic          sft_tx_req = 1'b0;
    logic [7:0]    sft_tx_byte;
    logic          sft_tx_vld;
    logic          sft_rx_vld = 1'b0;
    logic [7:0]    sft_rx_byte = 8'h00;
    logic [AW:0]   tx_level;
    logic [AW:0]   rx_level;
    logic [3:0]    buf_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    spi_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .buf_clr     (buf_clr),
        .err_clr     (err_clr),
        .tx_byte_vld (tx_byte_vld),
        .tx_byte     (tx_byte),
        .tx_buf_rdy  (tx_buf_rdy),
        .rx_byte_req (rx_byte_req),
        .rx_byte     (rx_byte),
        .rx_buf_rdy  (rx_buf_rdy),
        .sft_tx_req  (sft_tx_req),
        .sft_tx_byte (sft_tx_byte),
        .sft_tx_vld  (sft_tx_vld),
        .sft_rx_vld  (sft_rx_vld),
        .sft_rx_byte (sft_rx_byte),
        .tx_level    (tx_level),
        .rx_level    (rx_level),
        .buf_err     (buf_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] tq[$];
    logic [7:0] rq[$];
    logic [3:0] merr = 4'h0;
    bit         m_tpop, m_tpush, m_rpop, m_rpush;
    logic [3:0] m_new;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tq.delete();
            rq.delete();
            merr = 4'h0;
        end else if (buf_clr) begin
            tq.delete();
            rq.delete();
            merr = 4'h0;
        end else begin
            m_tpop  = sft_tx_req && (tq.size() != 0);
            m_tpush = tx_byte_vld && ((tq.size() < DEPTH) || m_tpop);
            m_rpop  = rx_byte_req && (rq.size() != 0);
            m_rpush = sft_rx_vld && ((rq.size() < DEPTH) || m_rpop);
            m_new   = {rx_byte_req && !m_rpop, sft_rx_vld && !m_rpush,
                       sft_tx_req && !m_tpop, tx_byte_vld && !m_tpush};
            if (m_tpop) void'(tq.pop_front());
            if (m_tpush) tq.push_back(tx_byte);
            if (m_rpop) void'(rq.pop_front());
            if (m_rpush) rq.push_back(sft_rx_byte);
            merr = (err_clr ? 4'h0 : merr) | m_new;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rstn) begin
            chk("m_tx_level", 32'(tx_level), 32'(tq.size()));
            chk("m_rx_level", 32'(rx_level), 32'(rq.size()));
            chk("m_tx_buf_rdy", 32'(tx_buf_rdy), 32'(tq.size() < DEPTH));
            chk("m_sft_tx_vld", 32'(sft_tx_vld), 32'(tq.size() != 0));
            chk("m_rx_buf_rdy", 32'(rx_buf_rdy), 32'(rq.size() != 0));
            chk("m_buf_err", 32'(buf_err), 32'(merr));
            if (tq.size() != 0) chk("m_sft_tx_byte", 32'(sft_tx_byte), 32'(tq[0]));
            if (rq.size() != 0) chk("m_rx_byte", 32'(rx_byte), 32'(rq[0]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tx_buf_rdy"}, 32'(tx_buf_rdy), 32'd1);
        chk({tag, "_rx_buf_rdy"}, 32'(rx_buf_rdy), 32'd0);
        chk({tag, "_sft_tx_vld"}, 32'(sft_tx_vld), 32'd0);
        chk({tag, "_tx_level"}, 32'(tx_level), 32'd0);
        chk({tag, "_rx_level"}, 32'(rx_level), 32'd0);
        chk({tag, "_buf_err"}, 32'(buf_err), 32'd0);
    endtask

    logic [7:0] exp_order [8];
    logic [7:0] exp_head;

    initial begin
        // 1. reset
        #2 rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst_hold");
        @(posedge clk);
        #1 rstn = 1'b1;
        step();
        @(negedge clk);
        chk_reset_vals("rst_rel");
        $display("[TB] reset released");

        // 2. fill TX with 0x11..0x18
        for (int i = 0; i < 8; i++) begin
            tx_byte_vld = 1'b1;
            tx_byte = 8'h11 + 8'(i);
            step();
            $display("[TB] tx push %02h", tx_byte);
        end
        tx_byte_vld = 1'b0;
        @(negedge clk);
        chk("fill_tx_level", 32'(tx_level), 32'd8);
        chk("fill_tx_rdy", 32'(tx_buf_rdy), 32'd0);
        chk("fill_head", 32'(sft_tx_byte), 32'h11);

        // 3. overflow then push+pop while full
        tx_byte_vld = 1'b1;
        tx_byte = 8'hAA;
        step();
        tx_byte_vld = 1'b0;
        @(negedge clk);
        chk("ovf_flag", 32'(buf_err), 32'h1);
        chk("ovf_level", 32'(tx_level), 32'd8);
        $display("[TB] tx push AA while full, buf_err=%h", buf_err);
        tx_byte_vld = 1'b1;
        sft_tx_req = 1'b1;
        step();
        tx_byte_vld = 1'b0;
        sft_tx_req = 1'b0;
        @(negedge clk);
        chk("fullpp_level", 32'(tx_level), 32'd8);
        chk("fullpp_err", 32'(buf_err), 32'h1);
        $display("[TB] tx push+pop while full, level=%0d", tx_level);
        exp_order = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'hAA};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("drain_order", 32'(sft_tx_byte), 32'(exp_order[i]));
            chk("drain_vld", 32'(sft_tx_vld), 32'd1);
            $display("[TB] tx pop %02h", sft_tx_byte);
            sft_tx_req = 1'b1;
            step();
            sft_tx_req = 1'b0;
        end
        @(negedge clk);
        chk("drain_vld_low", 32'(sft_tx_vld), 32'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        @(negedge clk);
        chk("errclr", 32'(buf_err), 32'h0);

        // 4. RX single byte and underflow
        sft_rx_vld = 1'b1;
        sft_rx_byte = 8'h5A;
        step();
        sft_rx_vld = 1'b0;
        @(negedge clk);
        chk("rx_rdy", 32'(rx_buf_rdy), 32'd1);
        chk("rx_byte", 32'(rx_byte), 32'h5A);
        rx_byte_req = 1'b1;
        $display("[TB] rx pop %02h", rx_byte);
        step();
        rx_byte_req = 1'b0;
        @(negedge clk);
        chk("rx_rdy_low", 32'(rx_buf_rdy), 32'd0);
        rx_byte_req = 1'b1;
        step();
        rx_byte_req = 1'b0;
        @(negedge clk);
        chk("rx_udf", 32'(buf_err), 32'h8);
        err_clr = 1'b1;
        rx_byte_req = 1'b1;
        step();
        rx_byte_req = 1'b0;
        @(negedge clk);
        chk("errclr_vs_new", 32'(buf_err), 32'h8);
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        @(negedge clk);
        chk("errclr2", 32'(buf_err), 32'h0);
        $display("[TB] rx underflow and err_clr checked");

        // 5. RX wrap at level 3
        for (int i = 0; i < 3; i++) begin
            sft_rx_vld = 1'b1;
            sft_rx_byte = 8'h30 + 8'(i);
            step();
        end
        sft_rx_vld = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            exp_head = (i < 3) ? 8'h30 + 8'(i) : 8'h40 + 8'(i - 3);
            chk("wrap_head", 32'(rx_byte), 32'(exp_head));
            chk("wrap_level", 32'(rx_level), 32'd3);
            $display("[TB] rx wrap pop %02h push %02h", rx_byte, 8'h40 + 8'(i));
            sft_rx_vld = 1'b1;
            sft_rx_byte = 8'h40 + 8'(i);
            rx_byte_req = 1'b1;
            step();
            sft_rx_vld = 1'b0;
            rx_byte_req = 1'b0;
        end
        for (int i = 17; i < 20; i++) begin
            @(negedge clk);
            chk("wrap_tail", 32'(rx_byte), 32'(8'h40 + 8'(i)));
            rx_byte_req = 1'b1;
            step();
            rx_byte_req = 1'b0;
        end
        @(negedge clk);
        chk("wrap_empty", 32'(rx_level), 32'd0);

        // 6. buf_clr at tx_level=5 with a pending error and a push
        for (int i = 0; i < 5; i++) begin
            tx_byte_vld = 1'b1;
            tx_byte = 8'hC0 + 8'(i);
            step();
        end
        tx_byte_vld = 1'b0;
        rx_byte_req = 1'b1;
        step();
        rx_byte_req = 1'b0;
        @(negedge clk);
        chk("preclr_level", 32'(tx_level), 32'd5);
        chk("preclr_err", 32'(buf_err), 32'h8);
        buf_clr = 1'b1;
        tx_byte_vld = 1'b1;
        tx_byte = 8'hEE;
        step();
        buf_clr = 1'b0;
        tx_byte_vld = 1'b0;
        @(negedge clk);
        chk("clr_level", 32'(tx_level), 32'd0);
        chk("clr_err", 32'(buf_err), 32'h0);
        $display("[TB] buf_clr with push, tx_level=%0d", tx_level);

        // async reset mid-transfer
        for (int i = 0; i < 3; i++) begin
            tx_byte_vld = 1'b1;
            tx_byte = 8'hD0 + 8'(i);
            sft_rx_vld = 1'b1;
            sft_rx_byte = 8'hE0 + 8'(i);
            step();
        end
        #2 rstn = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        $display("[TB] async reset mid-transfer");
        tx_byte_vld = 1'b0;
        sft_rx_vld = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        step();
        @(negedge clk);
        chk_reset_vals("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
